// File: rtl/rv_bus_uart.sv
// Memory-mapped UART for the RISC-V Lite IO region: TX FIFO, one-byte RX holding
// register, sticky error flags and a programmable baud divisor behind a registered read port.
module rv_bus_uart #(
    parameter int          BUS_ADDR_DATA_LEN  = 13,
    parameter int          DATA_ADDR          = 'h20,
    parameter int          STATUS_ADDR        = 'h24,
    parameter int          BAUD_ADDR          = 'h28,
    parameter int          TX_FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] BAUD_RESET         = 16'd494
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
    input  logic                         wr_dat,
    input  logic                         rd_dat,
    input  logic [31:0]                  bus_dat_in,
    output logic [31:0]                  bus_dat_out,
    input  logic                         uart_rx,
    output logic                         uart_tx,
    output logic                         irq
);
    localparam int AW    = BUS_ADDR_DATA_LEN;
    localparam int L     = TX_FIFO_DEPTH_LOG2;
    localparam int PW    = TX_FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << TX_FIFO_DEPTH_LOG2;
    localparam logic [AW-1:0] DATA_OFS   = AW'(DATA_ADDR);
    localparam logic [AW-1:0] STATUS_OFS = AW'(STATUS_ADDR);
    localparam logic [AW-1:0] BAUD_OFS   = AW'(BAUD_ADDR);
    localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic sel_data, sel_status, sel_baud;
    assign sel_data   = (addr_dat[AW-1:2] == DATA_OFS[AW-1:2]);
    assign sel_status = (addr_dat[AW-1:2] == STATUS_OFS[AW-1:2]);
    assign sel_baud   = (addr_dat[AW-1:2] == BAUD_OFS[AW-1:2]);

    logic unused_bits;
    assign unused_bits = ^{bus_dat_in[31:16], addr_dat[1:0]};

    logic [15:0] divisor;
    logic        status_wr;
    assign status_wr = wr_dat & sel_status;

    // TX FIFO: extra pointer bit distinguishes full from empty
    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, fifo_fill;
    logic          fifo_empty, fifo_full, push_ok;
    assign fifo_fill  = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_fill == FULL_CNT);

    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_timer;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_tick, tx_pop, tx_busy;
    assign tx_tick = (tx_timer == divisor);
    assign tx_busy = (tx_state != TX_IDLE);
    assign push_ok = wr_dat & sel_data & (~fifo_full | tx_pop);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        unique case (tx_state)
            TX_IDLE:  if (!fifo_empty) begin
                          tx_pop       = 1'b1;
                          tx_state_nxt = TX_START;
                      end
            TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_tick) begin
                          if (!fifo_empty) begin
                              tx_pop       = 1'b1;
                              tx_state_nxt = TX_START;
                          end else begin
                              tx_state_nxt = TX_IDLE;
                          end
                      end
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_idx   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_timer <= (tx_state == TX_IDLE || tx_tick) ? 16'd0 : tx_timer + 16'd1;
            if (tx_state == TX_DATA && tx_tick) tx_idx <= tx_idx + 3'd1;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[L-1:0]] <= bus_dat_in[7:0];
        if (tx_pop)
            tx_shift <= fifo_mem[rd_ptr[L-1:0]];
        else if (tx_state == TX_DATA && tx_tick)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    assign uart_tx = (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // RX: two-flop synchronizer plus one more flop for falling-edge detection
    logic        rx_s1, rx_s2, rx_prev, rx_fall;
    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] rx_timer, rx_half_m1;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift, rx_byte;
    logic        rx_tick, rx_shift_en, rx_done, rx_load;
    logic        rx_valid, rx_overrun, frame_err;
    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_half_m1 = (divisor - 16'd1) >> 1;
    assign rx_tick    = (rx_state == RX_START) ? (rx_timer == rx_half_m1) : (rx_timer == divisor);
    assign rx_load    = rx_done & rx_s2 & ~rx_valid;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_shift_en  = 1'b0;
        rx_done      = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
            RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick) begin
                          rx_shift_en = 1'b1;
                          if (rx_idx == 3'd7) rx_state_nxt = RX_STOP;
                      end
            RX_STOP:  if (rx_tick) begin
                          rx_done      = 1'b1;
                          rx_state_nxt = RX_IDLE;
                      end
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_timer   <= '0;
            rx_idx     <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            divisor    <= BAUD_RESET;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_nxt;
            rx_timer <= (rx_state == RX_IDLE || rx_tick) ? 16'd0 : rx_timer + 16'd1;
            if (rx_shift_en) rx_idx <= rx_idx + 3'd1;
            // A byte arriving in the same cycle as a software clear keeps the flag set
            if (rx_load)                          rx_valid   <= 1'b1;
            else if (status_wr && bus_dat_in[2])  rx_valid   <= 1'b0;
            if (rx_done && rx_s2 && rx_valid)     rx_overrun <= 1'b1;
            else if (status_wr && bus_dat_in[3])  rx_overrun <= 1'b0;
            if (rx_done && !rx_s2)                frame_err  <= 1'b1;
            else if (status_wr && bus_dat_in[5])  frame_err  <= 1'b0;
            if (wr_dat && sel_baud)
                divisor <= (bus_dat_in[15:0] == 16'd0) ? 16'd1 : bus_dat_in[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rx_shift_en) rx_shift <= {rx_s2, rx_shift[7:1]};
        if (rx_load)     rx_byte  <= rx_shift;
    end

    assign irq = rx_valid | (fifo_empty & ~tx_busy);

    logic [31:0] rd_word, rd_data_p1;
    always_comb begin
        rd_word = '0;
        if (sel_data)
            rd_word = {23'b0, rx_valid, rx_byte};
        else if (sel_status)
            rd_word = {26'b0, frame_err, tx_busy, rx_overrun, rx_valid, fifo_empty, fifo_full};
        else if (sel_baud)
            rd_word = {16'b0, divisor};
    end

    // Read stage: one-cycle registered latency, zero when not selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_p1 <= '0;
        else     rd_data_p1 <= rd_dat ? rd_word : 32'd0;
    end

    assign bus_dat_out = rd_data_p1;
endmodule
